// File: rtl/fe_stage.sv
// -----------------------------------------------------------------------------
// fe_stage
//
// Fetch stage of the 5-stage pipeline. Issues one instruction-memory request
// at a time, lands the returning instruction in the FE pipeline latch toward
// decode, and squashes wrong-path work when execute redirects the PC.
//
// A one-entry skid buffer holds a response that arrives while decode is
// stalled. No new request is issued until the skid drains, so at most one
// instruction is ever parked outside the latch.
//
// State table:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_ISSUE | presenting pc_q on the request channel (if skid is empty)
//   S_WAIT  | one request accepted, waiting for its response
//   S_DROP  | a wrong-path request is outstanding; its response is discarded
//
// Ports:
//   clk              clock, all state updates on posedge
//   reset            asynchronous, active-high reset
//   from_AGEX_to_FE  {br_cond, target}; br_cond=1 redirects fetch to target
//   from_DE_to_FE    decode stall; 1 = decode cannot take the FE latch
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request when valid & ready
//   imem_req_addr    word-aligned fetch address
//   imem_resp_valid  response valid, one per accepted request
//   imem_resp_data   fetched instruction
//   FE_latch_out     {valid, inst, PC, pcplus, inst_count}, MSB first
// -----------------------------------------------------------------------------
module fe_stage #(
    parameter int              DBITS    = 32,
    parameter int              INSTBITS = 32,
    parameter logic [DBITS-1:0] START_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DBITS:0]                from_AGEX_to_FE,
    input  logic                          from_DE_to_FE,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [DBITS-1:0]              imem_req_addr,
    input  logic                          imem_resp_valid,
    input  logic [INSTBITS-1:0]           imem_resp_data,
    output logic [INSTBITS+3*DBITS:0]     FE_latch_out
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    localparam logic [DBITS-1:0] PC_STEP    = DBITS'(4);
    localparam logic [DBITS-1:0] ALIGN_MASK = ~DBITS'(3);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [DBITS-1:0]     pc_q, pc_d;
    logic [DBITS-1:0]     inflight_pc_q, inflight_pc_d;

    logic                 skid_valid_q, skid_valid_d;
    logic [INSTBITS-1:0]  skid_inst_q, skid_inst_d;
    logic [DBITS-1:0]     skid_pc_q, skid_pc_d;

    logic                 lat_valid_q, lat_valid_d;
    logic [INSTBITS-1:0]  lat_inst_q, lat_inst_d;
    logic [DBITS-1:0]     lat_pc_q, lat_pc_d;
    logic [DBITS-1:0]     lat_pcplus_q, lat_pcplus_d;
    logic [DBITS-1:0]     lat_count_q, lat_count_d;

    logic [DBITS-1:0]     inst_count_q, inst_count_d;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    logic             br_cond;
    logic [DBITS-1:0] br_target;
    logic             stall;
    logic             req_fire;
    logic             resp_in_wait;

    assign br_cond   = from_AGEX_to_FE[DBITS];
    assign br_target = from_AGEX_to_FE[DBITS-1:0];
    assign stall     = from_DE_to_FE;

    // Valid is gated by reset combinationally so nothing is presented to
    // memory while reset is held, not just after the first edge.
    assign imem_req_valid = (state_q == S_ISSUE) && !skid_valid_q && !reset;
    assign imem_req_addr  = pc_q;

    assign req_fire     = imem_req_valid && imem_req_ready;
    assign resp_in_wait = (state_q == S_WAIT) && imem_resp_valid;

    assign FE_latch_out = {lat_valid_q, lat_inst_q, lat_pc_q, lat_pcplus_q, lat_count_q};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_inst_d   = skid_inst_q;
        skid_pc_d     = skid_pc_q;
        lat_valid_d   = lat_valid_q;
        lat_inst_d    = lat_inst_q;
        lat_pc_d      = lat_pc_q;
        lat_pcplus_d  = lat_pcplus_q;
        lat_count_d   = lat_count_q;
        inst_count_d  = inst_count_q;

        // Request / response sequencing
        unique case (state_q)
            S_ISSUE: begin
                if (req_fire) begin
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + PC_STEP;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = S_ISSUE;
                    // Park the response when decode is stalled, or when the
                    // skid is occupied and must reach the latch first.
                    if (stall || skid_valid_q) begin
                        skid_valid_d = 1'b1;
                        skid_inst_d  = imem_resp_data;
                        skid_pc_d    = inflight_pc_q;
                    end
                end
            end
            S_DROP: begin
                if (imem_resp_valid) begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase

        // FE latch toward decode; held entirely while decode stalls
        if (!stall) begin
            if (skid_valid_q) begin
                lat_valid_d  = 1'b1;
                lat_inst_d   = skid_inst_q;
                lat_pc_d     = skid_pc_q;
                lat_pcplus_d = skid_pc_q + PC_STEP;
                lat_count_d  = inst_count_q + DBITS'(1);
                inst_count_d = inst_count_q + DBITS'(1);
                // The skid only stays full if it was refilled this cycle.
                skid_valid_d = resp_in_wait;
            end else if (resp_in_wait) begin
                lat_valid_d  = 1'b1;
                lat_inst_d   = imem_resp_data;
                lat_pc_d     = inflight_pc_q;
                lat_pcplus_d = inflight_pc_q + PC_STEP;
                lat_count_d  = inst_count_q + DBITS'(1);
                inst_count_d = inst_count_q + DBITS'(1);
            end else begin
                lat_valid_d = 1'b0;
            end
        end

        // Redirect overrides everything above. Nothing valid reaches the
        // latch this cycle, so the instruction count must not advance.
        if (br_cond) begin
            pc_d         = br_target & ALIGN_MASK;
            lat_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            inst_count_d = inst_count_q;
            // A request whose response is still to come must be drained.
            if (((state_q == S_WAIT) && !imem_resp_valid) ||
                ((state_q == S_DROP) && !imem_resp_valid) ||
                ((state_q == S_ISSUE) && req_fire)) begin
                state_d = S_DROP;
            end else begin
                state_d = S_ISSUE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_ISSUE;
            pc_q          <= START_PC;
            inflight_pc_q <= '0;
            skid_valid_q  <= 1'b0;
            skid_inst_q   <= '0;
            skid_pc_q     <= '0;
            lat_valid_q   <= 1'b0;
            lat_inst_q    <= '0;
            lat_pc_q      <= '0;
            lat_pcplus_q  <= '0;
            lat_count_q   <= '0;
            inst_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc_q     <= skid_pc_d;
            lat_valid_q   <= lat_valid_d;
            lat_inst_q    <= lat_inst_d;
            lat_pc_q      <= lat_pc_d;
            lat_pcplus_q  <= lat_pcplus_d;
            lat_count_q   <= lat_count_d;
            inst_count_q  <= inst_count_d;
        end
    end

endmodule

// File: tb/tb_fe_stage.sv
module tb_fe_stage;
    localparam int DB = 32;
    localparam int IB = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [DB:0]       agex;
    logic              stall;
    logic              req_valid;
    logic              req_ready;
    logic [DB-1:0]     req_addr;
    logic              resp_valid;
    logic [IB-1:0]     resp_data;
    logic [IB+3*DB:0]  latch;

    always #5 clk = ~clk;

    fe_stage #(.DBITS(DB), .INSTBITS(IB), .START_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .from_AGEX_to_FE (agex),
        .from_DE_to_FE   (stall),
        .imem_req_valid  (req_valid),
        .imem_req_ready  (req_ready),
        .imem_req_addr   (req_addr),
        .imem_resp_valid (resp_valid),
        .imem_resp_data  (resp_data),
        .FE_latch_out    (latch)
    );

    logic        lv;
    logic [31:0] linst, lpc, lpcplus, lcnt;
    assign lv      = latch[128];
    assign linst   = latch[127:96];
    assign lpc     = latch[95:64];
    assign lpcplus = latch[63:32];
    assign lcnt    = latch[31:0];

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction memory contents: unique word per address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        rsp;
        logic [31:0] rpc;
        logic        stl;
        logic        br;
        logic [31:0] tgt;
        logic        rv;
        logic [31:0] addr;
        logic        lv;
        logic [31:0] lpc;
        logic [31:0] lcnt;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] rpc,
                                input logic stl, input logic br, input logic [31:0] tgt,
                                input logic rv, input logic [31:0] addr,
                                input logic elv, input logic [31:0] elpc, input logic [31:0] elcnt);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.rpc = rpc; v.stl = stl; v.br = br; v.tgt = tgt;
        v.rv = rv; v.addr = addr; v.lv = elv; v.lpc = elpc; v.lcnt = elcnt;
        return v;
    endfunction

    // One cycle: check outputs held since the last posedge, then drive inputs.
    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        chk({nm, ".req_valid"}, 32'(req_valid), 32'(v.rv));
        chk({nm, ".req_addr"},  req_addr, v.addr);
        chk({nm, ".lat_valid"}, 32'(lv), 32'(v.lv));
        if (v.lv) begin
            chk({nm, ".lat_pc"},     lpc, v.lpc);
            chk({nm, ".lat_pcplus"}, lpcplus, v.lpc + 32'd4);
            chk({nm, ".lat_inst"},   linst, memf(v.lpc));
            chk({nm, ".lat_count"},  lcnt, v.lcnt);
        end
        req_ready  = v.rdy;
        resp_valid = v.rsp;
        resp_data  = memf(v.rpc);
        stall      = v.stl;
        agex       = {v.br, v.tgt};
    endtask

    vec_t tbl[16];

    // Random-phase reference model state
    logic [31:0] exp_pc, last_cnt, pend_addr, prev_addr, rtgt;
    int          pend_wait, deliv;
    bit          pend, redir, prev_rv, prev_hs, prev_br, rbr;

    initial begin
        //             rdy rsp rpc    stl br tgt      rv addr    lv lpc    cnt
        tbl[0]  = mk(1, 0, 0,     0, 0, 0,      1, 32'h0,  0, 0,     0);
        tbl[1]  = mk(0, 1, 32'h0, 0, 0, 0,      0, 32'h4,  0, 0,     0);
        tbl[2]  = mk(1, 0, 0,     0, 0, 0,      1, 32'h4,  1, 32'h0, 1);
        tbl[3]  = mk(0, 1, 32'h4, 0, 0, 0,      0, 32'h8,  0, 0,     0);
        tbl[4]  = mk(0, 0, 0,     0, 0, 0,      1, 32'h8,  1, 32'h4, 2);
        tbl[5]  = mk(0, 0, 0,     0, 0, 0,      1, 32'h8,  0, 0,     0);
        tbl[6]  = mk(0, 0, 0,     0, 0, 0,      1, 32'h8,  0, 0,     0);
        tbl[7]  = mk(1, 0, 0,     0, 0, 0,      1, 32'h8,  0, 0,     0);
        tbl[8]  = mk(0, 1, 32'h8, 0, 0, 0,      0, 32'hC,  0, 0,     0);
        tbl[9]  = mk(1, 0, 0,     1, 0, 0,      1, 32'hC,  1, 32'h8, 3);
        tbl[10] = mk(0, 1, 32'hC, 1, 0, 0,      0, 32'h10, 1, 32'h8, 3);
        tbl[11] = mk(1, 0, 0,     1, 0, 0,      0, 32'h10, 1, 32'h8, 3);
        tbl[12] = mk(1, 0, 0,     0, 0, 0,      0, 32'h10, 1, 32'h8, 3);
        tbl[13] = mk(1, 0, 0,     0, 0, 0,      1, 32'h10, 1, 32'hC, 4);
        tbl[14] = mk(0, 1, 32'h10,0, 0, 0,      0, 32'h14, 0, 0,     0);
        tbl[15] = mk(0, 0, 0,     0, 0, 0,      1, 32'h14, 1, 32'h10,5);

        reset = 1'b1; agex = '0; stall = 1'b0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_data = '0;
        repeat (2) @(negedge clk);
        chk("rst.req_valid", 32'(req_valid), 0);
        chk("rst.req_addr", req_addr, 32'h0);
        chk("rst.latch_nonzero", 32'(latch != '0), 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Redirect to 0x103 while waiting on 0x20; late response discarded.
        step(mk(0, 0, 0,      0, 1, 32'h20,  1, 32'h14,  0, 0, 0), "br.a");
        step(mk(1, 0, 0,      0, 0, 0,       1, 32'h20,  0, 0, 0), "br.b");
        step(mk(0, 0, 0,      0, 1, 32'h103, 0, 32'h24,  0, 0, 0), "br.c");
        step(mk(0, 1, 32'h20, 0, 0, 0,       0, 32'h100, 0, 0, 0), "br.d");
        step(mk(1, 0, 0,      0, 0, 0,       1, 32'h100, 0, 0, 0), "br.e");
        step(mk(0, 1, 32'h100,0, 0, 0,       0, 32'h104, 0, 0, 0), "br.f");
        // Redirect coinciding with a response under stall.
        step(mk(1, 0, 0,      1, 0, 0,       1, 32'h104, 1, 32'h100, 6), "brs.a");
        step(mk(0, 1, 32'h104,1, 1, 32'h200, 0, 32'h108, 1, 32'h100, 6), "brs.b");
        step(mk(0, 0, 0,      0, 0, 0,       1, 32'h200, 0, 0, 0), "brs.c");
        step(mk(1, 0, 0,      0, 0, 0,       1, 32'h200, 0, 0, 0), "brs.d");
        // Reset while in WAIT, then a stray response.
        step(mk(0, 0, 0,      0, 0, 0,       0, 32'h204, 0, 0, 0), "mrst.a");
        #1 reset = 1'b1;
        #1;
        chk("mrst.req_valid", 32'(req_valid), 0);
        chk("mrst.req_addr", req_addr, 32'h0);
        chk("mrst.latch_nonzero", 32'(latch != '0), 0);
        @(negedge clk);
        reset = 1'b0;
        step(mk(0, 1, 32'h200,0, 0, 0,       1, 32'h0, 0, 0, 0), "mrst.b");
        step(mk(1, 0, 0,      0, 0, 0,       1, 32'h0, 0, 0, 0), "mrst.c");
        step(mk(0, 1, 32'h0,  0, 0, 0,       0, 32'h4, 0, 0, 0), "mrst.d");
        step(mk(0, 0, 0,      0, 0, 0,       1, 32'h4, 1, 32'h0, 1), "mrst.e");

        // Randomized phase against a program-order reference model.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; agex = '0; stall = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
        exp_pc = 32'h0; last_cnt = 32'h0; pend = 0; redir = 0;
        prev_rv = 0; prev_hs = 0; prev_br = 0; deliv = 0; pend_wait = 0;
        pend_addr = '0; prev_addr = '0;

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (pend) chk("rnd.single_outstanding", 32'(req_valid), 0);
            if (prev_rv && !prev_hs && !prev_br) begin
                chk("rnd.valid_hold", 32'(req_valid), 1);
                chk("rnd.addr_hold", req_addr, prev_addr);
            end

            resp_valid = 1'b0;
            if (pend) begin
                if (pend_wait == 0) begin
                    resp_valid = 1'b1;
                    resp_data  = memf(pend_addr);
                    pend       = 0;
                end else begin
                    pend_wait--;
                end
            end
            stall     = ($urandom_range(0, 99) < 30);
            rbr       = ($urandom_range(0, 99) < 6);
            rtgt      = 32'($urandom_range(0, 32'h3FF));
            agex      = {rbr, rtgt};
            req_ready = ($urandom_range(0, 99) < 60);

            if (lv && !stall) begin
                chk("rnd.pc_order", lpc, exp_pc);
                chk("rnd.inst", linst, memf(exp_pc));
                chk("rnd.pcplus", lpcplus, exp_pc + 32'd4);
                if (!redir) begin
                    chk("rnd.count_step", lcnt, last_cnt + 32'd1);
                    last_cnt = last_cnt + 32'd1;
                end else begin
                    chk("rnd.count_grows", 32'(lcnt > last_cnt), 1);
                    last_cnt = lcnt;
                end
                exp_pc = exp_pc + 32'd4;
                redir  = 0;
                deliv++;
            end
            if (rbr) begin
                exp_pc = rtgt & ~32'd3;
                redir  = 1;
            end

            prev_hs = req_valid && req_ready;
            if (prev_hs) begin
                pend      = 1;
                pend_wait = $urandom_range(0, 2);
                pend_addr = req_addr;
            end
            prev_rv   = req_valid;
            prev_addr = req_addr;
            prev_br   = rbr;
        end
        chk("rnd.progress", 32'(deliv > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
